pe_cal_sequencer: RTL

//  PE-array side responder to the memory-control read/compute handshake. It starts when a

---
 rtl/pe_cal_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pe_cal_sequencer.sv
// PE-array side tile sequencer: after rd_done it clears the accumulators, counts operand
// beats, writes back result beats toward the buffer, then returns pe_end to the controller.
module pe_cal_sequencer #(
    parameter int CNT_W = 11,
    parameter int IDX_W = 9
) (
    input  logic             clk_cal,
    input  logic             rst_cal_n,
    input  logic             rd_done,
    input  logic [CNT_W-1:0] cal_cycle,
    input  logic [CNT_W-1:0] pass_cycle,
    input  logic             Data_O_vld,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             Data_I_vld,
    output logic [IDX_W-1:0] out_idx,
    output logic             pe_end,
    output logic             busy,
    output logic             err_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_CAL,
        S_PASS,
        S_END
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cal_len;
    logic [CNT_W-1:0] pass_len;
    logic [CNT_W-1:0] cal_cnt;
    logic [CNT_W-1:0] pass_cnt;

    assign acc_en  = (state == S_CAL) && Data_O_vld;
    assign out_idx = pass_cnt[IDX_W-1:0];

    // Registered outputs are loaded from the state being entered, so they line up with it.
    always_ff @(posedge clk_cal or negedge rst_cal_n) begin
        if (!rst_cal_n) begin
            state       <= S_IDLE;
            cal_len     <= '0;
            pass_len    <= '0;
            cal_cnt     <= '0;
            pass_cnt    <= '0;
            acc_clr     <= 1'b0;
            Data_I_vld  <= 1'b0;
            pe_end      <= 1'b0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            pe_end  <= 1'b0;
            if (rd_done && state != S_IDLE) begin
                err_overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (rd_done) begin
                        cal_len  <= cal_cycle;
                        pass_len <= pass_cycle;
                        state    <= S_CLR;
                        acc_clr  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (cal_len != '0) begin
                        state <= S_CAL;
                    end else if (pass_len != '0) begin
                        state      <= S_PASS;
                        Data_I_vld <= 1'b1;
                    end else begin
                        state  <= S_END;
                        pe_end <= 1'b1;
                    end
                end
                S_CAL: begin
                    // Invalid beats simply stall here; the buffer is trusted to deliver.
                    if (Data_O_vld) begin
                        if (cal_cnt == cal_len - ONE) begin
                            cal_cnt <= '0;
                            if (pass_len != '0) begin
                                state      <= S_PASS;
                                Data_I_vld <= 1'b1;
                            end else begin
                                state  <= S_END;
                                pe_end <= 1'b1;
                            end
                        end else begin
                            cal_cnt <= cal_cnt + ONE;
                        end
                    end
                end
                S_PASS: begin
                    if (pass_cnt == pass_len - ONE) begin
                        pass_cnt   <= '0;
                        Data_I_vld <= 1'b0;
                        state      <= S_END;
                        pe_end     <= 1'b1;
                    end else begin
                        pass_cnt <= pass_cnt + ONE;
                    end
                end
                S_END: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= S_IDLE;
                    cal_cnt    <= '0;
                    pass_cnt   <= '0;
                    Data_I_vld <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
